// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - roll/score BCD display source selector with play/game-over FSM
module score_display_ctrl #(
  parameter int DIGITS       = 2,
  parameter int SUM_W        = 4,
  parameter int BLINK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SUM_W-1:0]      sum,
  input  logic                  sum_valid,
  input  logic                  gameover,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  blank,
  output logic                  in_over,
  output logic                  score_ovf
);

  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_CYCLES - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [0:0] {PLAY = 1'b0, OVER = 1'b1} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] last_sum;
  logic [4*DIGITS-1:0] score;
  logic [CW-1:0]       cnt;

  logic [4*DIGITS-1:0] sum_bcd;
  logic [4*DIGITS-1:0] add_res;
  logic [4*DIGITS-1:0] score_next;
  logic                carry_out;
  logic [7:0]          sum8;

  // Binary roll sum is at most 99, so two BCD digits always suffice.
  always_comb begin
    sum8         = 8'(sum);
    sum_bcd      = '0;
    sum_bcd[3:0] = 4'(sum8 % 8'd10);
    sum_bcd[7:4] = 4'(sum8 / 8'd10);
  end

  always_comb begin
    logic       c;
    logic [4:0] d;
    c       = 1'b0;
    d       = '0;
    add_res = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = 5'(score[4*i +: 4]) + 5'(sum_bcd[4*i +: 4]) + 5'(c);
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      add_res[4*i +: 4] = d[3:0];
    end
    carry_out  = c;
    score_next = (carry_out || score_ovf) ? ALL_NINES : add_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLAY;
      last_sum  <= '0;
      score     <= '0;
      cnt       <= '0;
      blank     <= 1'b0;
      score_ovf <= 1'b0;
      digits    <= '0;
      in_over   <= 1'b0;
    end else if (clear) begin
      state     <= PLAY;
      last_sum  <= '0;
      score     <= '0;
      cnt       <= '0;
      blank     <= 1'b0;
      score_ovf <= 1'b0;
      digits    <= '0;
      in_over   <= 1'b0;
    end else if (state == PLAY) begin
      cnt   <= '0;
      blank <= 1'b0;
      if (sum_valid) begin
        last_sum  <= sum_bcd;
        score     <= score_next;
        score_ovf <= score_ovf | carry_out;
      end
      // A roll strobed with gameover still lands in the final score shown.
      if (gameover) begin
        state   <= OVER;
        in_over <= 1'b1;
        digits  <= sum_valid ? score_next : score;
      end else begin
        in_over <= 1'b0;
        digits  <= sum_valid ? sum_bcd : last_sum;
      end
    end else begin
      in_over <= 1'b1;
      digits  <= score;
      if (cnt == CNT_MAX) begin
        cnt   <= '0;
        blank <= ~blank;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - directed self-checking bench for score_display_ctrl
module tb_score_display_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sum = '0;
  logic       sum_valid = 1'b0;
  logic       gameover = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] digits;
  logic       blank;
  logic       in_over;
  logic       score_ovf;

  int passed = 0;
  int total  = 0;

  score_display_ctrl #(.DIGITS(2), .SUM_W(4), .BLINK_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sum(sum), .sum_valid(sum_valid),
    .gameover(gameover), .clear(clear), .digits(digits), .blank(blank),
    .in_over(in_over), .score_ovf(score_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] s);
    sum = s; sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if ({digits, blank, in_over, score_ovf} !== 11'd0) $display("FAIL reset_outputs: got %h expected 0", {digits, blank, in_over, score_ovf}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (digits !== 8'h00 || in_over !== 1'b0) $display("FAIL reset_release: digits %h in_over %b expected 00/0", digits, in_over); else passed++;
  endtask

  task automatic test_accumulate();
    logic [3:0] sv [3] = '{4'd7, 4'd12, 4'd9};
    logic [7:0] ev [3] = '{8'h07, 8'h12, 8'h09};
    for (int i = 0; i < 3; i++) begin
      strobe(sv[i]);
      total++; if (digits !== ev[i]) $display("FAIL acc_roll%0d: got %h expected %h", i, digits, ev[i]); else passed++;
    end
    gameover = 1'b1;
    tick();
    total++; if (digits !== 8'h28 || in_over !== 1'b1 || blank !== 1'b0)
      $display("FAIL acc_gameover: digits %h in_over %b blank %b expected 28/1/0", digits, in_over, blank); else passed++;
    gameover = 1'b0;
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 1; i <= 10; i++) begin
      strobe(4'd12);
      total++; if (score_ovf !== (i >= 9)) $display("FAIL sat_ovf%0d: got %b expected %b", i, score_ovf, (i >= 9)); else passed++;
    end
    total++; if (digits !== 8'h12) $display("FAIL sat_last: got %h expected 12", digits); else passed++;
    gameover = 1'b1;
    tick();
    total++; if (digits !== 8'h99 || in_over !== 1'b1) $display("FAIL sat_score: digits %h in_over %b expected 99/1", digits, in_over); else passed++;
  endtask

  task automatic test_clear();
    clear = 1'b1; sum = 4'd5; sum_valid = 1'b1;
    tick();
    clear = 1'b0; sum_valid = 1'b0; gameover = 1'b0;
    total++; if ({digits, blank, in_over, score_ovf} !== 11'd0)
      $display("FAIL clear_outputs: digits %h blank %b in_over %b ovf %b expected all 0", digits, blank, in_over, score_ovf); else passed++;
    strobe(4'd5);
    total++; if (digits !== 8'h05 || in_over !== 1'b0) $display("FAIL clear_next_roll: digits %h in_over %b expected 05/0", digits, in_over); else passed++;
  endtask

  task automatic test_simultaneous();
    do_clear();
    strobe(4'd15);
    total++; if (digits !== 8'h15) $display("FAIL sim_setup: got %h expected 15", digits); else passed++;
    sum = 4'd6; sum_valid = 1'b1; gameover = 1'b1;
    tick();
    sum_valid = 1'b0;
    total++; if (digits !== 8'h21 || in_over !== 1'b1) $display("FAIL sim_final_roll: digits %h in_over %b expected 21/1", digits, in_over); else passed++;
    strobe(4'd3);
    total++; if (digits !== 8'h21) $display("FAIL over_ignores_roll: got %h expected 21", digits); else passed++;
    gameover = 1'b0;
  endtask

  task automatic test_blink_and_async_reset();
    logic [11:0] pat = 12'b0000_1111_0000;
    do_clear();
    gameover = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 5) gameover = 1'b0;
      total++; if (blank !== pat[i] || in_over !== 1'b1)
        $display("FAIL blink%0d: blank %b in_over %b expected %b/1", i, blank, in_over, pat[i]); else passed++;
    end
    tick();
    total++; if (blank !== 1'b1) $display("FAIL blink12: got %b expected 1", blank); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({digits, blank, in_over, score_ovf} !== 11'd0)
      $display("FAIL async_reset: got %h expected 0", {digits, blank, in_over, score_ovf}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    strobe(4'd4);
    total++; if (digits !== 8'h04 || in_over !== 1'b0 || blank !== 1'b0)
      $display("FAIL after_reset_play: digits %h in_over %b blank %b expected 04/0/0", digits, in_over, blank); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] ev [3] = '{8'h03, 8'h04, 8'h05};
    do_clear();
    sum_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sum = 4'(3 + i);
      tick();
      total++; if (digits !== ev[i]) $display("FAIL b2b_roll%0d: got %h expected %h", i, digits, ev[i]); else passed++;
    end
    sum_valid = 1'b0;
    gameover = 1'b1;
    tick();
    gameover = 1'b0;
    total++; if (digits !== 8'h12) $display("FAIL b2b_score: got %h expected 12", digits); else passed++;
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_saturation();
    test_clear();
    test_simultaneous();
    test_blink_and_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
